key_matrix_scan: RTL and testbench
==================================

Name: key_matrix_scan

Overview:
- Scans a ROWS x COLS push-button key matrix on the board I/O header. This is the input-side counterpart of the column-scanned dot-matrix driver: it drives one-hot column strobes and reads the row returns.
- Debounces a single pressed key over whole scan frames.
- Delivers each new keypress as a code through a one-entry valid/ready buffer to the application logic.

Parameters:
- ROWS, 4, number of row return lines.
- COLS, 4, number of column scan lines.
- SCAN_DIV, 100, clk cycles per column step; must be >= 4.
- DEBOUNCE, 4, consecutive identical frames needed to accept a press or a release; range 1..15.
- CODE_W (derived localparam), clog2(ROWS*COLS); 4 with the defaults.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- key_scan  out  COLS  one-hot column strobe, active-high
- key_row  in  ROWS  row returns, asynchronous, active-high when the key in the strobed column is pressed
- key_code  out  CODE_W  code of the accepted key, row*COLS + col
- key_valid  out  1  key_code holds an unconsumed event
- key_ready  in  1  consumer accepts the event when key_valid && key_ready at a clk edge
- key_pressed  out  1  high while the debounced key is held
- key_overflow  out  1  sticky; an event was dropped because the buffer was full

Behaviour:
- Reset state (applied at the next clk edge, from any state): key_scan=1 (bit 0), key_code=0, key_valid=0, key_pressed=0, key_overflow=0, divider=0, FSM=IDLE, snapshot cleared.
- key_row passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- Divider counts 0..SCAN_DIV-1. tick = (divider == SCAN_DIV-1), then the divider wraps to 0.
- On tick:
  - store synchronized key_row into snapshot[col];
  - rotate key_scan left by one; bit COLS-1 wraps to bit 0.
- Frame end = tick while bit COLS-1 is strobed. The frame is classified from the completed snapshot:
  - NONE: no bits set.
  - SINGLE(k): exactly one bit set; k = row*COLS + col.
  - MULTI: two or more bits set.
- FSM, advanced only at frame end:
  - IDLE: SINGLE(k) -> DEB, cand=k, cnt=1. Anything else stays IDLE.
  - DEB: SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE -> HELD and emit(cand). NONE, MULTI or a different SINGLE -> IDLE, cnt=0.
  - HELD: NONE -> REL, cnt=1. Anything else stays HELD; no repeat events.
  - REL: NONE -> cnt+1. When cnt reaches DEBOUNCE -> IDLE. Any key seen -> HELD, with no new event.
  - DEBOUNCE=1: a single qualifying frame accepts the press or release directly.
- key_pressed = 1 in HELD and REL, registered, so it changes the cycle after frame end.
- emit(k):
  - If key_valid=0, or key_valid && key_ready in that same cycle: load key_code=k and set key_valid=1 on the next edge.
  - Otherwise: discard k, keep key_code, set key_overflow=1.
- Handshake:
  - key_valid && key_ready with no emit: key_valid clears on the next edge.
  - key_code stays stable while key_valid=1.
- key_overflow clears only on reset.
- Latency: a press held stable from a frame start gives key_valid at DEBOUNCE*COLS*SCAN_DIV + 1 clocks (1601 with defaults). The worst case adds one frame for alignment, plus 2 clocks of synchronizer delay.

Test Plan:
- Reset, no keys -> key_scan steps 0001, 0010, 0100, 1000, 0001, each held 100 clocks; all other outputs 0; key_valid never rises.
- Key row2/col1 held (key_row[2]=1 whenever key_scan[1]=1), key_ready=1 -> key_valid pulses once with key_code=9 after 4 frames. key_pressed stays high until 4 NONE frames after release, then returns to 0.
- Bounce: key 9 present 3 frames, absent 1 frame, repeated 5 times -> no key_valid, key_pressed stays 0.
- Keys 0 and 5 held together for 10 frames -> no event, key_pressed=0. Then release key 5 -> after 4 frames key_valid with key_code=0.
- key_ready=0: press and release key 5, then press key 6 -> key_code stays 5, key_overflow=1. Raise key_ready -> key_valid drops next clock; key_overflow stays 1.
- Assert reset for 1 clock mid-DEB, and again with key_valid pending -> next clock key_scan=0001, key_valid=0, key_overflow=0, key_pressed=0. A held key then needs a full 4 frames again before key_valid.

Source files
------------

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: column-scanned push-button matrix reader.
// Strobes one column at a time and captures the row returns of each column into a frame snapshot.
// Debounces a single key over whole frames and hands each new press to the application.
// Each press is delivered through a one-entry valid/ready buffer.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   key_scan     one-hot column strobe, active-high
//   key_row      row returns (asynchronous), active-high when pressed
//   key_code     accepted key, row*COLS + col
//   key_valid    key_code holds an unconsumed event
//   key_ready    consumer accepts the event when key_valid && key_ready
//   key_pressed  debounced key is held
//   key_overflow sticky: an event was dropped because the buffer was full
module key_matrix_scan #(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 100,
  parameter int unsigned DEBOUNCE = 4,
  localparam int unsigned CODE_W  = $clog2(ROWS * COLS)
) (
  input  logic              clk,
  input  logic              reset,
  output logic [COLS-1:0]   key_scan,
  input  logic [ROWS-1:0]   key_row,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_pressed,
  output logic              key_overflow
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned DIV_W = $clog2(SCAN_DIV);
  localparam logic [3:0]  DEB_CNT = 4'(DEBOUNCE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEB,
    S_HELD,
    S_REL
  } state_t;

  logic [ROWS-1:0]   r_row_meta;
  logic [ROWS-1:0]   r_row_sync;
  logic [DIV_W-1:0]  r_div;
  logic [COLS-1:0]   r_scan;
  logic [COL_W-1:0]  r_col;
  logic [ROWS-1:0]   r_snap [COLS];

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [3:0]        w_cnt_inc;
  logic [CODE_W-1:0] r_cand;
  logic [CODE_W-1:0] w_cand_nxt;

  logic              r_pressed;
  logic              r_valid;
  logic              r_overflow;
  logic [CODE_W-1:0] r_code;

  logic              w_tick;
  logic              w_frame_end;
  logic [ROWS-1:0]   w_frame [COLS];
  logic [1:0]        w_hits;
  logic [CODE_W-1:0] w_hit_code;
  logic              w_none;
  logic              w_single;
  logic              w_emit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_meta <= '0;
      r_row_sync <= '0;
    end else begin
      r_row_meta <= key_row;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_tick      = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_frame_end = w_tick && r_scan[COLS-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div  <= '0;
      r_scan <= COLS'(1);
      r_col  <= '0;
      for (int unsigned c = 0; c < COLS; c++) begin
        r_snap[c] <= '0;
      end
    end else if (w_tick) begin
      r_div         <= '0;
      r_snap[r_col] <= r_row_sync;
      r_scan        <= {r_scan[COLS-2:0], r_scan[COLS-1]};
      r_col         <= (r_col == COL_W'(COLS - 1)) ? '0 : r_col + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // The last column is classified from the live sample taken on the frame-end
  // tick, since its snapshot slot is only written on that same edge.
  always_comb begin
    for (int unsigned c = 0; c < COLS; c++) begin
      w_frame[c] = r_snap[c];
    end
    w_frame[COLS-1] = r_row_sync;
  end

  // Saturating hit count: only none / one / many matters.
  always_comb begin
    w_hits     = '0;
    w_hit_code = '0;
    for (int unsigned c = 0; c < COLS; c++) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (w_frame[c][r]) begin
          if (w_hits != 2'd2) begin
            w_hits = w_hits + 2'd1;
          end
          w_hit_code = CODE_W'(r * COLS + c);
        end
      end
    end
  end

  assign w_none    = (w_hits == 2'd0);
  assign w_single  = (w_hits == 2'd1);
  assign w_cnt_inc = r_cnt + 4'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cand    <= '0;
      r_pressed <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_cand    <= w_cand_nxt;
      r_pressed <= (w_state_nxt == S_HELD) || (w_state_nxt == S_REL);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_emit      = 1'b0;
    if (w_frame_end) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_single) begin
            w_cand_nxt = w_hit_code;
            if (DEBOUNCE == 1) begin
              w_state_nxt = S_HELD;
              w_cnt_nxt   = '0;
              w_emit      = 1'b1;
            end else begin
              w_state_nxt = S_DEB;
              w_cnt_nxt   = 4'd1;
            end
          end
        end
        S_DEB: begin
          if (w_single && (w_hit_code == r_cand)) begin
            if (w_cnt_inc == DEB_CNT) begin
              w_state_nxt = S_HELD;
              w_cnt_nxt   = '0;
              w_emit      = 1'b1;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        S_HELD: begin
          if (w_none) begin
            if (DEBOUNCE == 1) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = S_REL;
              w_cnt_nxt   = 4'd1;
            end
          end
        end
        S_REL: begin
          if (w_none) begin
            if (w_cnt_inc == DEB_CNT) begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = S_HELD;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A new event may replace one that is being consumed on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_code     <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_emit) begin
      if (!r_valid || key_ready) begin
        r_code  <= w_hit_code;
        r_valid <= 1'b1;
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (r_valid && key_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign key_scan     = r_scan;
  assign key_code     = r_code;
  assign key_valid    = r_valid;
  assign key_pressed  = r_pressed;
  assign key_overflow = r_overflow;

endmodule

// File: tb/tb_key_matrix_scan.sv
// tb_key_matrix_scan: directed bench for key_matrix_scan with default parameters.
// A key model drives key_row from the strobed column and a set of held keys.
module tb_key_matrix_scan;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;

  logic        clk;
  logic        reset;
  logic [3:0]  key_scan;
  logic [3:0]  key_row;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ready;
  logic        key_pressed;
  logic        key_overflow;

  logic [15:0] keys;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned valid_rises;
  int unsigned pressed_cycles;
  logic        prev_valid;

  key_matrix_scan #(
    .ROWS(4),
    .COLS(4),
    .SCAN_DIV(100),
    .DEBOUNCE(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_scan(key_scan),
    .key_row(key_row),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_pressed(key_pressed),
    .key_overflow(key_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    key_row = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        if (keys[r * COLS + c] && key_scan[c] === 1'b1) key_row[r] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1 && prev_valid !== 1'b1) valid_rises++;
    if (key_pressed === 1'b1) pressed_cycles++;
    prev_valid = key_valid;
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns at the first negedge after key_scan wraps from 1000 to 0001.
  task automatic next_frame();
    logic [3:0] prev;
    bit         found;
    prev  = key_scan;
    found = 1'b0;
    for (int unsigned n = 0; n < 600 && !found; n++) begin
      @(negedge clk);
      if (prev == 4'b1000 && key_scan == 4'b0001) found = 1'b1;
      prev = key_scan;
    end
    if (!found) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_timeout: got no frame wrap within 600 clocks, want one");
    end
  endtask

  task automatic wait_frames(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) next_frame();
  endtask

  task automatic test_reset();
    logic [3:0]  exp_scan;
    int unsigned bad_scan;
    int unsigned bad_out;
    int unsigned rises0;
    apply_reset();
    n_checks++;
    if (key_scan !== 4'b0001) begin
      n_errors++;
      $display("FAIL reset_scan: got %b want 0001", key_scan);
    end
    n_checks++;
    if (key_valid !== 1'b0 || key_pressed !== 1'b0 || key_overflow !== 1'b0 || key_code !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: got v=%b p=%b o=%b c=%0d want 0 0 0 0",
               key_valid, key_pressed, key_overflow, key_code);
    end
    rises0 = valid_rises;
    bad_out = 0;
    for (int unsigned s = 0; s < 5; s++) begin
      exp_scan = 4'b0001 << (s % 4);
      bad_scan = 0;
      for (int unsigned j = 0; j < 100; j++) begin
        if (key_scan !== exp_scan) bad_scan++;
        if (key_valid !== 1'b0 || key_pressed !== 1'b0 || key_overflow !== 1'b0 || key_code !== 4'd0) bad_out++;
        @(negedge clk);
      end
      n_checks++;
      if (bad_scan != 0) begin
        n_errors++;
        $display("FAIL scan_step%0d: got %0d of 100 cycles off, want %b for all 100", s, bad_scan, exp_scan);
      end
    end
    n_checks++;
    if (bad_out != 0 || valid_rises != rises0) begin
      n_errors++;
      $display("FAIL idle_outputs: got %0d nonzero cycles, %0d valid rises, want 0 and 0",
               bad_out, valid_rises - rises0);
    end
  endtask

  task automatic test_press();
    int unsigned rises0;
    key_ready = 1'b1;
    next_frame();
    rises0 = valid_rises;
    keys = 16'h0200;
    wait_frames(3);
    n_checks++;
    if (key_valid !== 1'b0 || key_pressed !== 1'b0) begin
      n_errors++;
      $display("FAIL press_early: got v=%b p=%b after 3 frames, want 0 0", key_valid, key_pressed);
    end
    next_frame();
    n_checks++;
    if (key_valid !== 1'b1 || key_code !== 4'd9 || key_pressed !== 1'b1) begin
      n_errors++;
      $display("FAIL press_accept: got v=%b c=%0d p=%b want 1 9 1", key_valid, key_code, key_pressed);
    end
    @(negedge clk);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL press_consume: got v=%b want 0", key_valid);
    end
    wait_frames(2);
    n_checks++;
    if (valid_rises - rises0 != 1 || key_pressed !== 1'b1) begin
      n_errors++;
      $display("FAIL press_once: got %0d events p=%b want 1 event p=1", valid_rises - rises0, key_pressed);
    end
    keys = 16'h0000;
    wait_frames(3);
    n_checks++;
    if (key_pressed !== 1'b1) begin
      n_errors++;
      $display("FAIL release_early: got p=%b after 3 empty frames, want 1", key_pressed);
    end
    next_frame();
    n_checks++;
    if (key_pressed !== 1'b0) begin
      n_errors++;
      $display("FAIL release_done: got p=%b after 4 empty frames, want 0", key_pressed);
    end
  endtask

  task automatic test_bounce();
    int unsigned rises0;
    int unsigned press0;
    next_frame();
    rises0 = valid_rises;
    press0 = pressed_cycles;
    for (int unsigned i = 0; i < 5; i++) begin
      keys = 16'h0200;
      wait_frames(3);
      keys = 16'h0000;
      wait_frames(1);
    end
    next_frame();
    n_checks++;
    if (valid_rises != rises0 || pressed_cycles != press0) begin
      n_errors++;
      $display("FAIL bounce: got %0d events %0d pressed cycles, want 0 0",
               valid_rises - rises0, pressed_cycles - press0);
    end
  endtask

  task automatic test_multi();
    int unsigned rises0;
    int unsigned press0;
    rises0 = valid_rises;
    press0 = pressed_cycles;
    keys = 16'h0021;
    wait_frames(10);
    n_checks++;
    if (valid_rises != rises0 || pressed_cycles != press0) begin
      n_errors++;
      $display("FAIL multi_ignored: got %0d events %0d pressed cycles, want 0 0",
               valid_rises - rises0, pressed_cycles - press0);
    end
    keys = 16'h0001;
    wait_frames(3);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL multi_early: got v=%b want 0", key_valid);
    end
    next_frame();
    n_checks++;
    if (key_valid !== 1'b1 || key_code !== 4'd0) begin
      n_errors++;
      $display("FAIL multi_single: got v=%b c=%0d want 1 0", key_valid, key_code);
    end
    keys = 16'h0000;
    wait_frames(4);
    n_checks++;
    if (key_pressed !== 1'b0) begin
      n_errors++;
      $display("FAIL multi_release: got p=%b want 0", key_pressed);
    end
  endtask

  task automatic test_overflow();
    key_ready = 1'b0;
    keys = 16'h0020;
    wait_frames(4);
    n_checks++;
    if (key_valid !== 1'b1 || key_code !== 4'd5 || key_overflow !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_first: got v=%b c=%0d o=%b want 1 5 0", key_valid, key_code, key_overflow);
    end
    keys = 16'h0000;
    wait_frames(4);
    n_checks++;
    if (key_pressed !== 1'b0 || key_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_release: got p=%b v=%b want 0 1", key_pressed, key_valid);
    end
    keys = 16'h0040;
    wait_frames(4);
    n_checks++;
    if (key_overflow !== 1'b1 || key_code !== 4'd5 || key_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_drop: got o=%b c=%0d v=%b want 1 5 1", key_overflow, key_code, key_valid);
    end
    key_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (key_valid !== 1'b0 || key_overflow !== 1'b1) begin
      n_errors++;
      $display("FAIL ovf_drain: got v=%b o=%b want 0 1", key_valid, key_overflow);
    end
    keys = 16'h0000;
    wait_frames(4);
    key_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    key_ready = 1'b0;
    next_frame();
    keys = 16'h0200;
    wait_frames(2);
    apply_reset();
    n_checks++;
    if (key_scan !== 4'b0001 || key_valid !== 1'b0 || key_overflow !== 1'b0 || key_pressed !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_deb: got s=%b v=%b o=%b p=%b want 0001 0 0 0",
               key_scan, key_valid, key_overflow, key_pressed);
    end
    wait_frames(3);
    n_checks++;
    if (key_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_redeb: got v=%b after 3 frames want 0", key_valid);
    end
    next_frame();
    n_checks++;
    if (key_valid !== 1'b1 || key_code !== 4'd9) begin
      n_errors++;
      $display("FAIL reset_accept: got v=%b c=%0d want 1 9", key_valid, key_code);
    end
    apply_reset();
    n_checks++;
    if (key_scan !== 4'b0001 || key_valid !== 1'b0 || key_overflow !== 1'b0 ||
        key_pressed !== 1'b0 || key_code !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_pending: got s=%b v=%b o=%b p=%b c=%0d want 0001 0 0 0 0",
               key_scan, key_valid, key_overflow, key_pressed, key_code);
    end
    keys = 16'h0000;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    valid_rises    = 0;
    pressed_cycles = 0;
    reset          = 1'b1;
    key_ready      = 1'b0;
    keys           = '0;
    test_reset();
    test_press();
    test_bounce();
    test_multi();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
